inputc: RTL and testbench
=========================

Name: inputc

Overview:
Input channel of a router port; the receiving end of the link driven by the upstream router's output channel. It accepts flits tagged with a virtual channel (VC) and buffers them in one FIFO per VC (2 VCs). It presents each VC's head flit to the switch stage. It returns one credit pulse per flit dequeued, and a per-VC lock that stays high while any packet is still resident on that VC.

Parameters:
ROUTERID, 0, router index (informational, no logic effect)
PCHID, 0, physical channel index (informational)
DATAW, 32, flit width; bits [DATAW-1:DATAW-2] carry the flit type: 00 none, 01 head, 10 body, 11 tail
FIFOD, 8, per-VC FIFO depth in flits (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
idata  in  DATAW  incoming flit
ivalid  in  1  flit valid this cycle
ivch  in  1  VC of incoming flit
odata0  out  DATAW  head flit of VC0 FIFO (0 when empty)
odata1  out  DATAW  head flit of VC1 FIFO (0 when empty)
ovalid  out  2  bit v = VC v FIFO non-empty
ideq  in  2  switch dequeue strobe per VC
oack  out  2  credit return to upstream, one pulse per dequeued flit
olck  out  2  VC v holds at least one unfinished packet
oerr  out  1  sticky protocol/overflow error

Behaviour:
- Reset: all FIFO pointers and counts = 0; ovalid = 0; odata0/odata1 = 0; oack = 0; olck = 0; oerr = 0; both enqueue FSMs = EIDLE; packet counters = 0. Reset mid-packet discards all buffered flits immediately, with no credits returned.
- FIFO per VC: circular buffer with rd/wr pointers of log2(FIFOD) bits and a count of log2(FIFOD)+1 bits.
  - Pointers wrap from FIFOD-1 to 0.
  - odataN is combinational from mem[rd]; it is forced to 0 when the count is 0.
- Enqueue: on clk with ivalid=1, the flit is written to FIFO[ivch] if accepted. There is no backpressure; the upstream credit counter guarantees space.
- Enqueue FSM per VC, advanced only on accepted writes to that VC:
  - EIDLE + head -> EPKT, accept.
  - EPKT + body -> EPKT, accept.
  - EPKT + tail -> EIDLE, accept.
  - EIDLE + body/tail, EPKT + head, or any type 00 -> drop flit, set oerr, state unchanged.
- Overflow: a write to a VC with count==FIFOD is dropped and sets oerr. The exception is ideq for that VC in the same cycle, in which case both the write and the read happen. oerr clears only on reset.
- Dequeue: ideq[v]=1 with count>0 advances rd and decrements the count. ideq[v]=1 on an empty FIFO is ignored: no credit, no error.
- Simultaneous enqueue and dequeue on the same VC: count unchanged, both pointers advance.
- Credit: oack[v] is registered, high for exactly one cycle in the cycle after each valid dequeue. One flit equals one credit. No credit is returned for dropped flits.
- Lock: pktcnt[v] has log2(FIFOD)+1 bits.
  - It increments on an accepted head write to VC v.
  - It decrements on a valid dequeue of a tail flit from VC v.
  - Same-cycle increment and decrement leave it unchanged.
  - olck[v] is registered and equals (pktcnt_next[v] != 0); it rises the cycle after the head is accepted.
- Latency: a flit written at edge N is visible on odataN/ovalid after edge N (zero-bubble). A flit can be dequeued in the cycle after it is written.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with VC0 holding 3 flits -> immediately ovalid=00, olck=00, oack=00, oerr=0, odata0=0.
- Single packet VC0: head, body, body, tail in 4 consecutive cycles, then ideq[0]=1 for 4 cycles -> ovalid[0]=1 after the first edge; olck[0]=1 from the cycle after the head until the cycle after the tail dequeue; oack[0] pulses 4 times, each one cycle after a dequeue; FIFO returns empty.
- Interleaved VCs with FIFOD=8: alternate VC0 and VC1 flits, 8 each, no dequeue -> both counts = 8 and oerr=0. A 9th flit to VC1 without ideq[1] -> dropped, oerr=1, count stays 8. A 9th flit to VC0 with ideq[0]=1 in the same cycle -> accepted, count stays 8.
- Wrap-around: stream 20 flits (5 four-flit packets) through VC1, dequeuing each flit one cycle after its write -> output order matches input, 20 oack[1] pulses, pointers wrap twice, olck[1] returns to 0.
- Protocol error: body flit to VC0 in EIDLE, or a type-00 flit -> not stored, ovalid[0] unchanged, oerr=1. A following head flit is still accepted normally.
- Two packets queued on VC0 (8 flits), then dequeue first tail only -> olck[0] stays 1 until the second tail is dequeued.

Source files
------------

// File: rtl/inputc.sv
// inputc: router input channel with one FIFO per VC, packet-framing check,
// credit return and per-VC packet lock.
module inputc #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int DATAW    = 32,
    parameter int FIFOD    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic             ivch,
    output logic [DATAW-1:0] odata0,
    output logic [DATAW-1:0] odata1,
    output logic [1:0]       ovalid,
    input  logic [1:0]       ideq,
    output logic [1:0]       oack,
    output logic [1:0]       olck,
    output logic             oerr
);
    localparam int AW = $clog2(FIFOD);
    localparam logic [AW:0] FULL = (AW+1)'(FIFOD);

    typedef enum logic {EIDLE, EPKT} state_t;

    if (FIFOD < 2 || (FIFOD & (FIFOD - 1)) != 0 || ROUTERID < 0 || PCHID < 0) begin : g_bad_param
        $error("inputc: FIFOD must be a power of two >= 2 and ids non-negative");
    end

    logic [1:0]       w_type;
    logic [DATAW-1:0] w_head [2];
    logic [1:0]       w_err;
    logic             r_err;

    assign w_type = idata[DATAW-1 -: 2];
    assign odata0 = w_head[0];
    assign odata1 = w_head[1];
    assign oerr   = r_err;

    for (genvar v = 0; v < 2; v++) begin : g_vc
        logic [DATAW-1:0] r_mem [FIFOD];
        logic [AW-1:0]    r_rd, r_wr;
        logic [AW:0]      r_cnt, r_pkt, w_pkt_nxt;
        logic             r_ack, r_lck;
        state_t           r_st, w_st_nxt;
        logic             w_req, w_deq, w_tail_out, w_proto, w_acc;

        assign w_req      = ivalid && (ivch == 1'(v));
        assign w_deq      = ideq[v] && (r_cnt != '0);
        assign w_tail_out = w_deq && (r_mem[r_rd][DATAW-1 -: 2] == 2'b11);

        always_ff @(posedge clk or posedge rst)
            if (rst) r_st <= EIDLE;
            else     r_st <= w_st_nxt;

        always_comb
            w_st_nxt = !w_acc ? r_st : (w_type == 2'b01) ? EPKT : (w_type == 2'b11) ? EIDLE : r_st;

        // a full FIFO still accepts when the same cycle frees a slot
        always_comb begin
            w_proto   = (r_st == EIDLE) ? (w_type == 2'b01) : (w_type == 2'b10 || w_type == 2'b11);
            w_acc     = w_req && w_proto && (r_cnt != FULL || w_deq);
            w_pkt_nxt = r_pkt + (AW+1)'(w_acc && w_type == 2'b01) - (AW+1)'(w_tail_out);
        end

        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
                r_pkt <= '0;
                r_ack <= 1'b0;
                r_lck <= 1'b0;
            end else begin
                r_rd  <= r_rd + AW'(w_deq);
                r_wr  <= r_wr + AW'(w_acc);
                r_cnt <= r_cnt + (AW+1)'(w_acc) - (AW+1)'(w_deq);
                r_pkt <= w_pkt_nxt;
                r_ack <= w_deq;
                r_lck <= (w_pkt_nxt != '0);
            end

        always_ff @(posedge clk)
            if (w_acc) r_mem[r_wr] <= idata;

        assign w_head[v] = (r_cnt != '0) ? r_mem[r_rd] : '0;
        assign w_err[v]  = w_req && !w_acc;
        assign ovalid[v] = (r_cnt != '0);
        assign oack[v]   = r_ack;
        assign olck[v]   = r_lck;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_err <= 1'b0;
        else     r_err <= r_err | (|w_err);
endmodule

// File: tb/tb_inputc.sv
// tb_inputc: randomized scoreboard bench for inputc against a queue-based
// model of per-VC buffering, packet framing, credits and locks.
module tb_inputc;
    localparam int DATAW = 32;
    localparam int FIFOD = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DATAW-1:0] idata = '0;
    logic             ivalid = 1'b0;
    logic             ivch = 1'b0;
    logic [1:0]       ideq = 2'b00;
    logic [DATAW-1:0] odata0, odata1;
    logic [1:0]       ovalid, oack, olck;
    logic             oerr;

    inputc #(.ROUTERID(0), .PCHID(0), .DATAW(DATAW), .FIFOD(FIFOD)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .odata0(odata0), .odata1(odata1), .ovalid(ovalid), .ideq(ideq),
        .oack(oack), .olck(olck), .oerr(oerr)
    );

    always #5 clk = ~clk;

    logic [DATAW-1:0] mq [2][$];
    logic [DATAW-1:0] sb [2][$];
    bit               mpkt [2];
    int               mpc [2];
    logic [1:0]       m_ack, m_lck;
    logic             m_err;
    bit               mon_en = 1'b0;
    int               vectors = 0;
    int               miscompares = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    // One clock of stimulus; the model advances right after the edge.
    task automatic step(input bit vld, input logic [1:0] typ, input bit ch, input logic [1:0] deq);
        logic [DATAW-1:0] d, f;
        bit ok [2];
        bit tl [2];
        bit acc;
        d = {typ, (DATAW-2)'($urandom)};
        ivalid = vld;
        ivch   = ch;
        idata  = d;
        ideq   = deq;
        for (int i = 0; i < 2; i++) begin
            ok[i] = deq[i] && mq[i].size() > 0;
            tl[i] = 1'b0;
            if (ok[i]) begin
                f = mq[i][0];
                tl[i] = (f[DATAW-1 -: 2] == 2'b11);
                sb[i].push_back(f);
            end
        end
        acc = vld && (mpkt[ch] ? (typ == 2'b10 || typ == 2'b11) : typ == 2'b01)
                  && (mq[ch].size() < FIFOD || ok[ch]);
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            if (ok[i]) void'(mq[i].pop_front());
        if (acc) begin
            mq[ch].push_back(d);
            if (typ == 2'b01) begin mpkt[ch] = 1'b1; mpc[ch]++; end
            if (typ == 2'b11) mpkt[ch] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (tl[i]) mpc[i]--;
            m_lck[i] = (mpc[i] != 0);
            m_ack[i] = ok[i];
        end
        m_err = m_err | (vld && !acc);
        #1;
        ivalid = 1'b0;
        ideq   = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'b00, 1'b0, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ivalid = 1'b0;
        ideq = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            sb[i].delete();
            mpkt[i] = 1'b0;
            mpc[i] = 0;
        end
        m_ack = 2'b00;
        m_lck = 2'b00;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a flit that is dequeued.
    always @(negedge clk) begin : mon
        logic [DATAW-1:0] got, exp_h;
        if (mon_en && !rst) begin
            for (int i = 0; i < 2; i++) begin
                got = (i != 0) ? odata1 : odata0;
                if (ideq[i] && ovalid[i]) begin
                    if (sb[i].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL deq_unexpected vc%0d: got %0h expected no flit", i, got);
                    end else chk($sformatf("deq_data_vc%0d", i), got, sb[i].pop_front());
                end
                exp_h = (mq[i].size() != 0) ? mq[i][0] : '0;
                chk($sformatf("head_vc%0d", i), got, exp_h);
            end
            chk("ovalid", 32'(ovalid), 32'({mq[1].size() != 0, mq[0].size() != 0}));
            chk("oack", 32'(oack), 32'(m_ack));
            chk("olck", 32'(olck), 32'(m_lck));
            chk("oerr", 32'(oerr), 32'(m_err));
        end
    end

    initial begin
        do_reset();
        mon_en = 1'b1;
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_odata0", odata0, 32'd0);
        chk("rst_olck", 32'(olck), 32'd0);
        chk("rst_oerr", 32'(oerr), 32'd0);
        // single packet on VC0
        step(1, 2'b01, 0, 2'b00);
        step(1, 2'b10, 0, 2'b00);
        step(1, 2'b10, 0, 2'b00);
        step(1, 2'b11, 0, 2'b00);
        repeat (4) step(0, 2'b00, 0, 2'b01);
        idle(2);
        // asynchronous reset mid-packet with 3 flits resident and a credit in flight
        step(1, 2'b00, 0, 2'b00);
        step(1, 2'b01, 0, 2'b00);
        step(1, 2'b10, 0, 2'b00);
        step(1, 2'b10, 0, 2'b00);
        step(1, 2'b10, 0, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("arst_ovalid", 32'(ovalid), 32'd0);
        chk("arst_olck", 32'(olck), 32'd0);
        chk("arst_oack", 32'(oack), 32'd0);
        chk("arst_oerr", 32'(oerr), 32'd0);
        chk("arst_odata0", odata0, 32'd0);
        do_reset();
        // interleaved fill to full, then overflow on each VC
        for (int k = 0; k < FIFOD; k++) begin
            step(1, (k == 0) ? 2'b01 : (k == FIFOD - 1) ? 2'b11 : 2'b10, 0, 2'b00);
            step(1, (k == 0) ? 2'b01 : (k == FIFOD - 1) ? 2'b11 : 2'b10, 1, 2'b00);
        end
        step(1, 2'b01, 1, 2'b00);
        step(1, 2'b01, 0, 2'b01);
        repeat (FIFOD) step(0, 2'b00, 0, 2'b11);
        idle(2);
        do_reset();
        // wrap-around streaming on VC1
        for (int k = 0; k < 20; k++)
            step(1, (k % 4 == 0) ? 2'b01 : (k % 4 == 3) ? 2'b11 : 2'b10, 1, (k != 0) ? 2'b10 : 2'b00);
        step(0, 2'b00, 0, 2'b10);
        idle(2);
        do_reset();
        // framing errors, then recovery
        step(1, 2'b10, 0, 2'b00);
        step(1, 2'b00, 0, 2'b00);
        step(1, 2'b11, 0, 2'b00);
        step(1, 2'b01, 0, 2'b00);
        step(1, 2'b01, 0, 2'b00);
        step(1, 2'b11, 0, 2'b00);
        repeat (2) step(0, 2'b00, 0, 2'b01);
        idle(1);
        do_reset();
        // two packets resident: lock holds until the second tail leaves
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++)
                step(1, (k == 0) ? 2'b01 : (k == 3) ? 2'b11 : 2'b10, 0, 2'b00);
        repeat (4) step(0, 2'b00, 0, 2'b01);
        idle(2);
        repeat (4) step(0, 2'b00, 0, 2'b01);
        idle(2);
        do_reset();
        // random traffic
        repeat (400) begin
            int r;
            r = $urandom_range(0, 9);
            step($urandom_range(0, 3) != 0,
                 (r == 0) ? 2'b00 : (r < 3) ? 2'b01 : (r < 5) ? 2'b11 : 2'b10,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        repeat (FIFOD + 2) step(0, 2'b00, 0, 2'b11);
        idle(2);
        chk("sb_left_vc0", sb[0].size(), 32'd0);
        chk("sb_left_vc1", sb[1].size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
